// File: rtl/vc_scheduler.sv
// vc_scheduler: credit-based round-robin VC plane scheduler that locks onto a VC for a whole packet.
// Optional macro VC_SCHED_CREDIT_ERR_EN adds a sticky credit_err output for bad credit returns.
module vc_scheduler #(
    parameter int VC           = 4,
    parameter int CREDIT_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [VC-1:0] emptyVC,
    input  logic [VC-1:0] tailVC,
    input  logic          out_ready,
    input  logic          credit_valid,
    input  logic [VC:0]   credit_vc,
    output logic [VC:0]   VCPlaneSelector,
    output logic          rd_en,
    output logic          out_valid,
    output logic          busy
`ifdef VC_SCHED_CREDIT_ERR_EN
    ,
    output logic          credit_err
`endif
);
    localparam int IW = VC + 1;
    localparam int CW = $clog2(CREDIT_DEPTH + 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] sel_q, sel_d, rr_q, rr_d;
    logic [IW-1:0] off, sum, pick;
    logic [CW-1:0] credit_q [VC];
    logic [CW-1:0] credit_d [VC];
    logic [VC-1:0] elig, ring;
    logic          sel_ok, sel_tail;

    // Rotate the eligibility vector so bit 0 is rr_q; the lowest set bit is the grant offset.
    always_comb begin
        for (int i = 0; i < VC; i++)
            elig[i] = !emptyVC[i] && (credit_q[i] != '0);
        ring = VC'({elig, elig} >> rr_q);
        off = '0;
        for (int k = VC - 1; k >= 0; k--)
            if (ring[k]) off = IW'(k);
        sum  = rr_q + off;
        pick = (sum >= IW'(VC)) ? sum - IW'(VC) : sum;
        sel_ok   = 1'b0;
        sel_tail = 1'b0;
        for (int i = 0; i < VC; i++)
            if (sel_q == IW'(i)) begin
                sel_ok   = elig[i];
                sel_tail = tailVC[i];
            end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        rr_d    = rr_q;
        if (state_q == IDLE && |elig) begin
            state_d = SEND;
            sel_d   = pick;
        end
        if (rd_en && sel_tail) begin
            state_d = IDLE;
            rr_d    = (sel_q == IW'(VC - 1)) ? '0 : sel_q + 1'b1;
        end
    end

    always_comb begin
        busy      = state_q == SEND;
        out_valid = busy && sel_ok;
        rd_en     = out_valid && out_ready;
    end

    assign VCPlaneSelector = sel_q;

    // A return and a pop on the same VC cancel; returns at full credit saturate.
    always_comb begin
        for (int i = 0; i < VC; i++) begin
            credit_d[i] = credit_q[i];
            if (credit_valid && credit_vc == IW'(i) && !(rd_en && sel_q == IW'(i))
                && credit_q[i] != CW'(CREDIT_DEPTH))
                credit_d[i] = credit_q[i] + 1'b1;
            else if (rd_en && sel_q == IW'(i) && !(credit_valid && credit_vc == IW'(i)))
                credit_d[i] = credit_q[i] - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            rr_q    <= '0;
            for (int i = 0; i < VC; i++)
                credit_q[i] <= CW'(CREDIT_DEPTH);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
            for (int i = 0; i < VC; i++)
                credit_q[i] <= credit_d[i];
        end
    end

`ifdef VC_SCHED_CREDIT_ERR_EN
    logic err_q, err_d, ret_full;

    always_comb begin
        ret_full = 1'b0;
        for (int i = 0; i < VC; i++)
            if (credit_vc == IW'(i) && credit_q[i] == CW'(CREDIT_DEPTH)) ret_full = 1'b1;
        err_d = err_q || (credit_valid && (credit_vc >= IW'(VC) || ret_full));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign credit_err = err_q;
`endif
endmodule

// File: tb/tb_vc_scheduler.sv
// tb_vc_scheduler: directed scenario bench for vc_scheduler (VC=4, CREDIT_DEPTH=4).
module tb_vc_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] emptyVC = 4'hF;
    logic [3:0] tailVC = 4'h0;
    logic       out_ready = 1'b0;
    logic       credit_valid = 1'b0;
    logic [4:0] credit_vc = 5'd0;
    logic [4:0] sel;
    logic       rd_en, out_valid, busy;
`ifdef VC_SCHED_CREDIT_ERR_EN
    logic       credit_err;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vc_scheduler #(.VC(4), .CREDIT_DEPTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .emptyVC(emptyVC),
        .tailVC(tailVC),
        .out_ready(out_ready),
        .credit_valid(credit_valid),
        .credit_vc(credit_vc),
        .VCPlaneSelector(sel),
        .rd_en(rd_en),
        .out_valid(out_valid),
        .busy(busy)
`ifdef VC_SCHED_CREDIT_ERR_EN
        ,
        .credit_err(credit_err)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        emptyVC = 4'hF;
        tailVC = 4'h0;
        out_ready = 1'b0;
        credit_valid = 1'b0;
        credit_vc = 5'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        rst_n = 1'b0;
        emptyVC = 4'h0;
        tailVC = 4'hF;
        out_ready = 1'b1;
        tick();
        tick();
        checks++; if (sel !== 5'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
`ifdef VC_SCHED_CREDIT_ERR_EN
        checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_credit_err: got %b expected 0", credit_err); end
`endif
    endtask

    task automatic test_round_robin;
        do_reset();
        emptyVC = 4'h0;
        tailVC = 4'hF;
        out_ready = 1'b1;
        #1;
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rr_idle: rd_en got %b expected 0", rd_en); end
        for (int g = 0; g < 5; g++) begin
            tick();
            checks++; if (sel !== 5'(g % 4)) begin errors++; $display("FAIL rr_grant%0d: sel got %0d expected %0d", g, sel, g % 4); end
            checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL rr_pop%0d: rd_en got %b expected 1", g, rd_en); end
            tick();
            checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: rd_en got %b expected 0", g, rd_en); end
        end
    endtask

    task automatic test_packet_lock;
        do_reset();
        emptyVC = 4'b1001;
        tailVC = 4'h0;
        out_ready = 1'b1;
        tick();
        emptyVC = 4'b1000;
        #1;
        checks++; if (sel !== 5'd1 || rd_en !== 1'b1) begin errors++; $display("FAIL lock_first: sel=%0d rd_en=%b expected 1/1", sel, rd_en); end
        tick();
        out_ready = 1'b0;
        #1;
        checks++; if (rd_en !== 1'b0 || busy !== 1'b1 || sel !== 5'd1) begin errors++; $display("FAIL lock_stall: rd_en=%b busy=%b sel=%0d expected 0/1/1", rd_en, busy, sel); end
        tick();
        out_ready = 1'b1;
        #1;
        checks++; if (sel !== 5'd1 || rd_en !== 1'b1) begin errors++; $display("FAIL lock_second: sel=%0d rd_en=%b expected 1/1", sel, rd_en); end
        tick();
        tailVC = 4'b0010;
        #1;
        checks++; if (sel !== 5'd1 || rd_en !== 1'b1) begin errors++; $display("FAIL lock_tail: sel=%0d rd_en=%b expected 1/1", sel, rd_en); end
        tick();
        tailVC = 4'h0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_release: busy got %b expected 0", busy); end
        tick();
        checks++; if (sel !== 5'd2 || busy !== 1'b1) begin errors++; $display("FAIL lock_next_grant: sel=%0d busy=%b expected 2/1", sel, busy); end
    endtask

    task automatic test_credit_exhaustion;
        do_reset();
        emptyVC = 4'b1110;
        tailVC = 4'h0;
        out_ready = 1'b1;
        tick();
        for (int p = 0; p < 4; p++) begin
            checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL credit_pop%0d: rd_en got %b expected 1", p, rd_en); end
            tick();
        end
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL credit_empty: out_valid=%b busy=%b expected 0/1", out_valid, busy); end
`ifdef VC_SCHED_CREDIT_ERR_EN
        checks++; if (credit_err !== 1'b0) begin errors++; $display("FAIL credit_err_clean: got %b expected 0", credit_err); end
`endif
        credit_valid = 1'b1;
        credit_vc = 5'd0;
        tick();
        credit_valid = 1'b0;
        #1;
        checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL credit_fifth_pop: rd_en got %b expected 1", rd_en); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL credit_reexhaust: out_valid got %b expected 0", out_valid); end
        credit_valid = 1'b1;
        credit_vc = 5'd4;
        tick();
        credit_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL credit_out_of_range: out_valid got %b expected 0", out_valid); end
`ifdef VC_SCHED_CREDIT_ERR_EN
        checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL credit_err_range: got %b expected 1", credit_err); end
`endif
    endtask

    task automatic test_simultaneous;
        int n;
        do_reset();
        emptyVC = 4'b1011;
        tailVC = 4'h0;
        out_ready = 1'b1;
        tick();
        checks++; if (sel !== 5'd2 || rd_en !== 1'b1) begin errors++; $display("FAIL sim_first: sel=%0d rd_en=%b expected 2/1", sel, rd_en); end
        tick();
        credit_valid = 1'b1;
        credit_vc = 5'd2;
        #1;
        checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL sim_overlap_pop: rd_en got %b expected 1", rd_en); end
        tick();
        credit_valid = 1'b0;
        #1;
        n = 0;
        repeat (6) begin
            if (rd_en === 1'b1) n++;
            tick();
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL sim_remaining_pops: got %0d expected 3", n); end
        do_reset();
        credit_valid = 1'b1;
        credit_vc = 5'd1;
        tick();
        credit_valid = 1'b0;
        #1;
`ifdef VC_SCHED_CREDIT_ERR_EN
        checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL sim_err_full: got %b expected 1", credit_err); end
`endif
        emptyVC = 4'b1101;
        out_ready = 1'b1;
        tick();
        checks++; if (sel !== 5'd1) begin errors++; $display("FAIL sim_full_grant: sel got %0d expected 1", sel); end
        n = 0;
        repeat (7) begin
            if (rd_en === 1'b1) n++;
            tick();
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL sim_saturate_pops: got %0d expected 4", n); end
    endtask

    task automatic test_mid_reset;
        int n;
        do_reset();
        emptyVC = 4'b1110;
        tailVC = 4'b0001;
        out_ready = 1'b1;
        tick();
        checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL mid_pre_pop: rd_en got %b expected 1", rd_en); end
        tick();
        emptyVC = 4'b0111;
        tailVC = 4'h0;
        tick();
        checks++; if (sel !== 5'd3 || rd_en !== 1'b1) begin errors++; $display("FAIL mid_vc3: sel=%0d rd_en=%b expected 3/1", sel, rd_en); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (sel !== 5'd0) begin errors++; $display("FAIL mid_sel: got %0d expected 0", sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL mid_rd_en: got %b expected 0", rd_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        tick();
        rst_n = 1'b1;
        emptyVC = 4'h0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle: busy got %b expected 0", busy); end
        tick();
        checks++; if (sel !== 5'd0) begin errors++; $display("FAIL mid_regrant: sel got %0d expected 0", sel); end
        n = 0;
        repeat (6) begin
            if (rd_en === 1'b1) n++;
            tick();
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL mid_credit_restore: pops got %0d expected 4", n); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_packet_lock();
        test_credit_exhaustion();
        test_simultaneous();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
